// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (I/D) arbiter onto a shared pipelined memory
// Fixed D priority; block fills issue BURST reads, writes are a single cycle.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int BURST   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_valid,
  output logic [2:0]  i_word,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_data,
  output logic        d_valid,
  output logic [2:0]  d_word,
  output logic        d_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        busy
);

  typedef enum logic [2:0] {DRAIN, IDLE, FILL_I, FILL_D, WRITE_D} state_t;

  localparam logic [3:0] LAST_WORD  = 4'(BURST - 1);
  localparam logic [7:0] LAST_DRAIN = 8'(LATENCY - 1);

  state_t      state;
  logic [3:0]  issue_cnt;
  logic [3:0]  ret_cnt;
  logic [7:0]  drain_cnt;
  logic [11:0] base;
  logic [3:0]  next_issue;
  logic        take;
  logic        last_take;
  logic        unused_addr_bits;

  assign next_issue       = issue_cnt + 4'd1;
  assign take             = mem_data_valid && (state == FILL_I || state == FILL_D);
  assign last_take        = take && (ret_cnt == LAST_WORD);
  assign unused_addr_bits = ^i_addr[3:0];

  assign i_data  = mem_data_out;
  assign i_valid = take && (state == FILL_I);
  assign i_done  = last_take && (state == FILL_I);
  assign i_word  = ret_cnt[2:0];

  assign d_data  = mem_data_out;
  assign d_valid = take && (state == FILL_D);
  assign d_done  = (last_take && (state == FILL_D)) || (state == WRITE_D);
  assign d_word  = ret_cnt[2:0];

  // DRAIN counts as busy, but not while reset is still held
  assign busy = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DRAIN;
      issue_cnt   <= 4'd0;
      ret_cnt     <= 4'd0;
      drain_cnt   <= 8'd0;
      base        <= 12'd0;
      mem_addr    <= 16'd0;
      mem_data_in <= 16'd0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
    end else begin
      case (state)
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) state <= IDLE;
          else drain_cnt <= drain_cnt + 8'd1;
        end
        IDLE: begin
          if (d_req) begin
            base       <= d_addr[15:4];
            issue_cnt  <= 4'd0;
            ret_cnt    <= 4'd0;
            mem_enable <= 1'b1;
            mem_wr     <= d_wr;
            if (d_wr) begin
              state       <= WRITE_D;
              mem_addr    <= d_addr;
              mem_data_in <= d_wdata;
            end else begin
              state    <= FILL_D;
              mem_addr <= {d_addr[15:4], 4'h0};
            end
          end else if (i_req) begin
            base       <= i_addr[15:4];
            issue_cnt  <= 4'd0;
            ret_cnt    <= 4'd0;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            state      <= FILL_I;
            mem_addr   <= {i_addr[15:4], 4'h0};
          end
        end
        FILL_I, FILL_D: begin
          // issue_cnt is the index of the read currently on the bus
          if (mem_enable) begin
            if (issue_cnt != LAST_WORD) begin
              issue_cnt <= next_issue;
              mem_addr  <= {base, next_issue[2:0], 1'b0};
            end else begin
              mem_enable <= 1'b0;
            end
          end
          if (take) begin
            ret_cnt <= ret_cnt + 4'd1;
            if (ret_cnt == LAST_WORD) begin
              state      <= IDLE;
              mem_enable <= 1'b0;
            end
          end
        end
        WRITE_D: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Timeline model of grants/issues/returns plus directed literal checks.
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int BUR = 8;
  localparam int O_NONE = 0, O_FI = 1, O_FD = 2, O_W = 3;
  localparam int W_EN = 0, W_IDONE = 1, W_DDONE = 2, W_IWORD3 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
  logic [15:0] i_data, d_data, mem_addr, mem_data_in, mem_data_out;
  logic        i_valid, i_done, d_valid, d_done, mem_enable, mem_wr, mem_data_valid, busy;
  logic [2:0]  i_word, d_word;
  logic        force_valid = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mem_arbiter #(.LATENCY(LAT), .BURST(BUR)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
    .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data(d_data), .d_valid(d_valid), .d_word(d_word), .d_done(d_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Shared memory: read data returns LAT cycles after the issue cycle
  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];
  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = 16'h0; end
  always @(posedge clk) begin
    pipe_v[0] <= mem_enable && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign mem_data_valid = pipe_v[LAT-1] | force_valid;
  assign mem_data_out   = mem_fn(pipe_a[LAT-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: each grant at cycle g defines the whole transaction timeline
  int          owner = O_NONE;
  int          g = 0;
  int          free_cyc = 0;
  logic [15:0] m_base = 16'h0, m_wdata = 16'h0;
  logic        rst_prev = 1'b0, rst_seen = 1'b0;

  always @(negedge clk) begin
    int k, r;
    logic e_en, e_wr, e_v, e_done, chk_addr;
    logic [15:0] e_addr, e_data;
    if (rst) begin
      if (rst_prev) begin
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_valids", {i_valid, d_valid, i_done, d_done}, 0);
      end
      owner = O_NONE;
      rst_seen = 1'b1;
    end else if (rst_seen) begin
      if (rst_prev) free_cyc = cyc + LAT;
      e_en = 0; e_wr = 0; e_v = 0; e_done = 0; chk_addr = 0; e_addr = 0; e_data = 0;
      k = cyc - g - 1;
      r = k - LAT;
      if (owner == O_FI || owner == O_FD) begin
        if (k >= 0 && k < BUR) begin e_en = 1; chk_addr = 1; e_addr = m_base | 16'(2 * k); end
        if (r >= 0 && r < BUR) begin
          e_v = 1; e_done = (r == BUR - 1); e_data = mem_fn(m_base | 16'(2 * r));
        end
      end else if (owner == O_W && k == 0) begin
        e_en = 1; e_wr = 1; chk_addr = 1; e_addr = m_base; e_done = 1;
      end
      check("busy", busy, (cyc < free_cyc) ? 1 : 0);
      check("mem_enable", mem_enable, e_en);
      check("mem_wr", mem_wr, e_wr);
      if (chk_addr) check("mem_addr", mem_addr, e_addr);
      if (e_wr) check("mem_data_in", mem_data_in, m_wdata);
      check("i_valid", i_valid, (owner == O_FI) && e_v);
      check("i_done", i_done, (owner == O_FI) && e_done);
      check("d_valid", d_valid, (owner == O_FD) && e_v);
      check("d_done", d_done, ((owner == O_FD) && e_done) || ((owner == O_W) && e_done));
      if (owner == O_FI && e_v) begin check("i_word", i_word, r); check("i_data", i_data, e_data); end
      if (owner == O_FD && e_v) begin check("d_word", d_word, r); check("d_data", d_data, e_data); end
      if (owner != O_NONE && cyc == free_cyc - 1) owner = O_NONE;
      else if (owner == O_NONE && cyc >= free_cyc) begin
        if (d_req) begin
          g = cyc;
          owner = d_wr ? O_W : O_FD;
          m_base = d_wr ? d_addr : (d_addr & 16'hFFF0);
          m_wdata = d_wdata;
          free_cyc = d_wr ? cyc + 2 : cyc + BUR + LAT + 1;
        end else if (i_req) begin
          g = cyc;
          owner = O_FI;
          m_base = i_addr & 16'hFFF0;
          free_cyc = cyc + BUR + LAT + 1;
        end
      end
    end
    rst_prev = rst;
  end

  task automatic wait_for(input int what, output int n, output logic vseen);
    logic hit;
    n = 0;
    vseen = 1'b0;
    forever begin
      @(negedge clk);
      vseen = vseen | i_valid;
      case (what)
        W_EN:    hit = mem_enable;
        W_IDONE: hit = i_done;
        W_DDONE: hit = d_done;
        default: hit = i_valid && (i_word == 3'd3);
      endcase
      if (hit === 1'b1) break;
      n++;
      if (n > 200) begin check("wait_timeout", 0, 1); break; end
    end
  endtask

  initial begin
    int n, t0;
    logic vs;
    // Reset with i_req already high: DRAIN then I fill of 0x1236's block
    rst = 1; i_req = 1; i_addr = 16'h1236;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_for(W_EN, n, vs);
    check("drain_then_issue", n, 5);
    check("first_issue_addr", mem_addr, 16'h1230);
    t0 = cyc;
    @(posedge clk); #1 i_addr = 16'hFFFF;
    repeat (7) @(negedge clk);
    check("last_issue_addr", mem_addr, 16'h123E);
    wait_for(W_IDONE, n, vs);
    check("i_done_word", i_word, 7);
    check("i_done_offset", cyc - t0, 11);
    @(posedge clk); #1 i_req = 0;
    @(negedge clk);
    check("idle_after_fill", busy, 0);

    // Stray mem_data_valid while idle
    @(posedge clk); #1 force_valid = 1;
    @(negedge clk);
    check("stray_valid", {i_valid, d_valid, i_done, d_done}, 0);
    @(posedge clk); #1 force_valid = 0;

    // Simultaneous requests: D fill wins, then I fill from the next IDLE cycle
    @(posedge clk); #1 i_req = 1; i_addr = 16'h3456; d_req = 1; d_wr = 0; d_addr = 16'h2000;
    wait_for(W_EN, n, vs);
    check("d_first_addr", mem_addr, 16'h2000);
    @(posedge clk); #1 d_addr = 16'h7777;
    wait_for(W_DDONE, n, vs);
    check("d_done_word", d_word, 7);
    check("no_i_valid_in_fill_d", vs, 0);
    @(posedge clk); #1 d_req = 0;
    wait_for(W_EN, n, vs);
    check("i_after_d_gap", n, 1);
    check("i_after_d_addr", mem_addr, 16'h3450);
    wait_for(W_IDONE, n, vs);
    @(posedge clk); #1 i_req = 0;

    // Single-word write
    @(posedge clk); #1 d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    wait_for(W_DDONE, n, vs);
    check("wr_mem_wr", mem_wr, 1);
    check("wr_mem_addr", mem_addr, 16'h0040);
    check("wr_mem_data_in", mem_data_in, 16'hBEEF);
    @(posedge clk); #1 d_req = 0; d_wr = 0;
    @(negedge clk);
    check("idle_after_write", {busy, mem_enable, mem_wr}, 0);

    // Reset pulse mid I fill, then a fresh fill
    @(posedge clk); #1 i_req = 1; i_addr = 16'h5678;
    wait_for(W_IWORD3, n, vs);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("drain_busy", busy, 1);
    check("drain_outputs", {mem_enable, mem_wr, i_valid, i_done}, 0);
    wait_for(W_EN, n, vs);
    check("redrain_len", n, 4);
    check("no_stale_i_valid", vs, 0);
    check("refill_addr", mem_addr, 16'h5670);
    wait_for(W_IDONE, n, vs);
    check("refill_done_word", i_word, 7);
    @(posedge clk); #1 i_req = 0;

    // D fill with its address changed mid-fill
    @(posedge clk); #1 d_req = 1; d_addr = 16'hABCD;
    wait_for(W_EN, n, vs);
    check("d2_first_addr", mem_addr, 16'hABC0);
    @(posedge clk); #1 d_addr = 16'h0000;
    wait_for(W_DDONE, n, vs);
    @(posedge clk); #1 d_req = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, memory read latency in cycles from issue to mem_data_valid.
REQ-002 SHALL have parameter BURST, default 8, 16-bit words per cache-block fill (16-byte block).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  input  1  I-side block-fill request, level, held until i_done.
REQ-006 SHALL have port i_addr  input  16  I-side miss address.
REQ-007 SHALL have ports i_data  output  16, i_valid  output  1, i_word  output  3: returned word, qualifier, word index in block.
REQ-008 SHALL have port i_done  output  1  one-cycle pulse with the final I-side word.
REQ-009 SHALL have ports d_req  input  1, d_wr  input  1 (1 = single-word write, 0 = block fill), d_addr  input  16, d_wdata  input  16.
REQ-010 SHALL have ports d_data  output  16, d_valid  output  1, d_word  output  3, d_done  output  1, with the same meanings as the I side.
REQ-011 SHALL have ports mem_addr  output  16, mem_data_in  output  16, mem_enable  output  1, mem_wr  output  1 toward the shared memory.
REQ-012 SHALL have ports mem_data_out  input  16, mem_data_valid  input  1 from the shared memory.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states DRAIN, IDLE, FILL_I, FILL_D, WRITE_D.
REQ-015 IDLE, both requests low: SHALL remain in IDLE.
REQ-016 IDLE: d_req high SHALL win over i_req (fixed D priority); d_wr=1 -> WRITE_D, d_wr=0 -> FILL_D; else i_req -> FILL_I.
REQ-017 Grant SHALL latch the granted address and, for writes, d_wdata; requester inputs SHALL be ignored until that requester's done.
REQ-018 WRITE_D: exactly one cycle of mem_enable=1, mem_wr=1, mem_addr=latched d_addr, mem_data_in=latched d_wdata, d_done=1; next state IDLE.
REQ-019 FILL_x issue: on BURST consecutive cycles starting with the first FILL cycle, mem_enable=1, mem_wr=0, mem_addr={addr[15:4], k[2:0], 1'b0}, k=0..BURST-1; mem_enable=0 after the last issue.
REQ-020 FILL_x return: each mem_data_valid SHALL assert x_valid the same cycle, x_data=mem_data_out, x_word=return count 0..BURST-1 in order.
REQ-021 x_done SHALL assert with the BURST-th returned word; next state IDLE.
REQ-022 Requester SHALL drop req the cycle after done; a new grant may be issued from that IDLE cycle.
REQ-023 Issue and return counters SHALL be 4 bits, never wrap within a burst, clear on grant.
REQ-024 mem_data_valid outside FILL_I/FILL_D SHALL be ignored; all valid/done outputs stay 0.
REQ-025 Side not granted SHALL have valid, done = 0; i_data/d_data may carry mem_data_out at all times.
REQ-026 With LATENCY=4, i_req seen in IDLE at cycle 0: issues cycles 1-8, valid cycles 5-12, i_done cycle 12, IDLE cycle 13.

Reset
REQ-027 rst high at a clock edge SHALL force state DRAIN and clear counters and latched address/data, mid-burst included.
REQ-028 During and after reset all outputs SHALL be 0 (mem_enable, mem_wr, valids, dones, busy, mem_addr, mem_data_in).
REQ-029 DRAIN SHALL last LATENCY cycles after rst deasserts (busy=1) so stale read data returns unclaimed, then IDLE.

Verification
REQ-030 Reset release, i_req high from cycle 0, LATENCY=4, i_addr=0x1236 -> IDLE after 4 DRAIN cycles; mem_addr 0x1230..0x123E on 8 issue cycles; i_word 0..7; i_done with word 7.
REQ-031 i_req and d_req (d_wr=0, d_addr=0x2000) high together in IDLE -> FILL_D first, d_done, then FILL_I granted from the IDLE cycle after d_done; i_valid never high during FILL_D.
REQ-032 d_req, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> one cycle mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, d_done=1; next cycle IDLE.
REQ-033 rst pulsed after word 3 of an I fill -> outputs 0, DRAIN 4 cycles, the in-flight words 4-7 produce no i_valid, fresh fill completes normally.
REQ-034 mem_data_valid forced high in IDLE -> no valid/done; i_addr/d_addr changed mid-fill -> issued addresses unchanged.
